// File: rtl/apb_traffic_checker_if.sv
// apb_traffic_checker_if
// Processor-bus side of APB_Master: a single transfer request/response channel.
// Signals:
//   p_start   1-cycle transfer request
//   p_write   1 = write, 0 = read
//   p_sel     target slave select (0 = bus idle)
//   p_addr    transfer address
//   p_wdata   write data
//   p_rdata   read data, valid while xfer_done = 1
//   xfer_done transfer complete
// Modports: master = traffic source (drives request), slave = APB_Master side.
interface apb_traffic_checker_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int SEL_W  = 2
);
  logic              p_start;
  logic              p_write;
  logic [SEL_W-1:0]  p_sel;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic [DATA_W-1:0] p_rdata;
  logic              xfer_done;

  modport master (
    output p_start, p_write, p_sel, p_addr, p_wdata,
    input  p_rdata, xfer_done
  );

  modport slave (
    input  p_start, p_write, p_sel, p_addr, p_wdata,
    output p_rdata, xfer_done
  );
endinterface

// File: rtl/apb_traffic_checker.sv
// apb_traffic_checker
// Self-checking traffic source for the processor-bus side of APB_Master. Each
// iteration writes LFSR-chosen data to an LFSR-chosen slave/address, reads it
// back and compares, keeping saturating pass/fail/timeout counters.
// Ports:
//   clk       clock, rising edge
//   reset     synchronous, active-high
//   go        1-cycle start pulse, honoured only in IDLE/DONE
//   num_iter  iterations per run (sampled on go, 0 -> DONE directly)
//   seed      LFSR seed (sampled on go, 0 replaced by 16'hACE1)
//   bus       request/response channel towards APB_Master (master modport)
//   busy      run in progress
//   done      run finished, held until next go or reset
//   pass_cnt  readbacks matching written data
//   fail_cnt  readbacks mismatching
//   tmo_cnt   transfers that hit TIMEOUT
module apb_traffic_checker #(
  parameter int               DATA_W  = 8,
  parameter int               ADDR_W  = 8,
  parameter int               SEL_W   = 2,
  parameter int               NUM_CH  = 2,
  parameter int               PFX_CH  = 1,
  parameter int               PFX_W   = 2,
  parameter logic [PFX_W-1:0] PFX_VAL = 2'b01,
  parameter int               CNT_W   = 16,
  parameter int               TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [CNT_W-1:0]      num_iter,
  input  logic [15:0]           seed,
  apb_traffic_checker_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      pass_cnt,
  output logic [CNT_W-1:0]      fail_cnt,
  output logic [CNT_W-1:0]      tmo_cnt
);

  localparam logic [15:0]      LFSR_INIT = 16'hACE1;
  localparam logic [15:0]      LFSR_TAPS = 16'hB400;
  localparam int               TMR_W     = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, PICK, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, GAP, DONE
  } state_t;

  state_t            state, state_next;
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_n1;
  logic [TMR_W-1:0]  timer;
  logic [CNT_W-1:0]  iter;
  logic [CNT_W-1:0]  iter_nxt;
  logic [CNT_W-1:0]  n_iter;
  logic [DATA_W-1:0] rdata_q;
  logic [SEL_W-1:0]  pick_ch;
  logic [ADDR_W-1:0] pick_addr;
  logic              tmr_expired;

  // Galois right-shift LFSR; a non-zero state never maps to zero.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign lfsr_n1     = lfsr_step(lfsr);
  assign iter_nxt    = iter + 1'b1;
  assign tmr_expired = (timer == TMR_LIMIT);

  // Channel and address come from the stepped LFSR value; the prefix channel
  // (e.g. the I2C slave) gets its fixed MSBs overlaid.
  always_comb begin
    pick_ch   = SEL_W'(1 + (int'(lfsr_n1[1:0]) % NUM_CH));
    pick_addr = lfsr_n1[ADDR_W+1:2];
    if (PFX_CH != 0 && pick_ch == SEL_W'(PFX_CH)) begin
      pick_addr[ADDR_W-1 -: PFX_W] = PFX_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // xfer_done wins over an expiring timer in the same cycle; it is only
  // looked at in the wait states, so a response in the request cycle is lost.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (go) state_next = (num_iter == '0) ? DONE : PICK;
      PICK:       state_next = WR_REQ;
      WR_REQ:     state_next = WR_WAIT;
      WR_WAIT: begin
        if (bus.xfer_done)    state_next = RD_REQ;
        else if (tmr_expired) state_next = GAP;
      end
      RD_REQ:     state_next = RD_WAIT;
      RD_WAIT: begin
        if (bus.xfer_done)    state_next = CHECK;
        else if (tmr_expired) state_next = GAP;
      end
      CHECK:      state_next = GAP;
      GAP:        state_next = (iter_nxt == n_iter) ? DONE : PICK;
      default:    state_next = IDLE;
    endcase
  end

  // The request fields are loaded while leaving PICK so they are already
  // stable in the p_start cycle. Write data is the LFSR value after the
  // second step, which the LFSR itself reaches at the end of WR_REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr        <= LFSR_INIT;
      bus.p_write <= 1'b0;
      bus.p_sel   <= '0;
      bus.p_addr  <= '0;
      bus.p_wdata <= '0;
      rdata_q     <= '0;
      timer       <= '0;
      iter        <= '0;
      n_iter      <= '0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (go) begin
            lfsr     <= (seed == 16'h0000) ? LFSR_INIT : seed;
            n_iter   <= num_iter;
            iter     <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            tmo_cnt  <= '0;
          end
        end
        PICK: begin
          lfsr        <= lfsr_n1;
          bus.p_sel   <= pick_ch;
          bus.p_addr  <= pick_addr;
          bus.p_wdata <= DATA_W'(lfsr_step(lfsr_n1));
          bus.p_write <= 1'b1;
        end
        WR_REQ: begin
          lfsr  <= lfsr_n1;
          timer <= TMR_W'(1);
        end
        WR_WAIT: begin
          if (bus.xfer_done)    bus.p_write <= 1'b0;
          else if (tmr_expired) tmo_cnt <= sat_inc(tmo_cnt);
          else                  timer <= timer + 1'b1;
        end
        RD_REQ: begin
          timer <= TMR_W'(1);
        end
        RD_WAIT: begin
          if (bus.xfer_done)    rdata_q <= bus.p_rdata;
          else if (tmr_expired) tmo_cnt <= sat_inc(tmo_cnt);
          else                  timer <= timer + 1'b1;
        end
        CHECK: begin
          if (rdata_q == bus.p_wdata) pass_cnt <= sat_inc(pass_cnt);
          else                        fail_cnt <= sat_inc(fail_cnt);
        end
        GAP: begin
          bus.p_sel <= '0;
          iter      <= iter_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.p_start = (state == WR_REQ) || (state == RD_REQ);
  assign busy        = (state != IDLE) && (state != DONE);
  assign done        = (state == DONE);

endmodule

// File: tb/tb_apb_traffic_checker.sv
// tb_apb_traffic_checker
// Drives apb_traffic_checker against a memory slave model (configurable
// latency, optional corruption on sel=2, optional no-response) and compares
// the observed write trace and result counters with a reference model that
// recomputes each iteration's slave/address/data from the seed.
module tb_apb_traffic_checker;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int SEL_W  = 2;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 16;
  localparam int TMO    = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic             go;
  logic [CNT_W-1:0] num_iter;
  logic [15:0]      seed;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] tmo_cnt;

  int total = 0;
  int bad   = 0;

  apb_traffic_checker_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) bus ();

  apb_traffic_checker #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEL_W(SEL_W), .NUM_CH(NUM_CH),
    .PFX_CH(1), .PFX_W(2), .PFX_VAL(2'b01), .CNT_W(CNT_W), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .num_iter(num_iter), .seed(seed),
    .bus(bus), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .tmo_cnt(tmo_cnt)
  );

  always #5 clk = ~clk;

  // Slave model: mode 0 ideal memory, 1 returns data^1 on sel=2, 2 never answers.
  int slave_lat  = 2;
  int slave_mode = 0;
  int pend       = 0;
  logic [SEL_W+ADDR_W-1:0] pend_key;
  logic [DATA_W-1:0] mem [0:(1<<(SEL_W+ADDR_W))-1];

  always @(negedge clk) begin
    bus.xfer_done = 1'b0;
    if (reset) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.xfer_done = 1'b1;
          bus.p_rdata   = mem[pend_key];
          if (slave_mode == 1 && pend_key[SEL_W+ADDR_W-1 -: SEL_W] == 2) bus.p_rdata = mem[pend_key] ^ 8'h01;
        end
      end
      if (bus.p_start && slave_mode != 2) begin
        pend     = slave_lat;
        pend_key = {bus.p_sel, bus.p_addr};
        if (bus.p_write) mem[pend_key] = bus.p_wdata;
      end
    end
  end

  // Bus monitor: records every write request and audits reads/selects.
  int          cyc = 0;
  logic [31:0] obs_wr[$];
  int          wr_cyc[$];
  int          rd_count = 0;
  int          rd_bad = 0;
  int          sel_bad = 0;
  int          start_count = 0;
  logic [SEL_W+ADDR_W-1:0] last_key = '0;

  always @(negedge clk) begin
    cyc++;
    if (bus.p_start === 1'b1) begin
      start_count++;
      if (bus.p_sel == 0 || int'(bus.p_sel) > NUM_CH) sel_bad++;
      if (bus.p_write) begin
        obs_wr.push_back(32'({bus.p_sel, bus.p_addr, bus.p_wdata}));
        wr_cyc.push_back(cyc);
        last_key = {bus.p_sel, bus.p_addr};
      end else begin
        rd_count++;
        if ({bus.p_sel, bus.p_addr} != last_key) rd_bad++;
      end
    end
  end

  // Reference model: expected {sel, addr, wdata} per iteration.
  logic [31:0] exp_wr[$];
  int          exp_ch2;

  function automatic int lfsrNext(input int v);
    return (v >> 1) ^ ((v % 2) != 0 ? 46080 : 0);
  endfunction

  task automatic buildExpected(input int s, input int n);
    int l, ch, addr, wd;
    exp_wr.delete();
    exp_ch2 = 0;
    l = (s == 0) ? 'hACE1 : s;
    for (int i = 0; i < n; i++) begin
      l    = lfsrNext(l);
      ch   = 1 + (l % 4) % NUM_CH;
      addr = (l / 4) % 256;
      if (ch == 1) addr = (addr % 64) + 64;
      l    = lfsrNext(l);
      wd   = l % 256;
      if (ch == 2) exp_ch2++;
      exp_wr.push_back(32'(ch * 65536 + addr * 256 + wd));
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int n, input int s);
    @(negedge clk);
    num_iter = CNT_W'(n);
    seed     = 16'(s);
    go       = 1'b1;
    @(negedge clk);
    go       = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic compareTrace(input string tag, input int base);
    int pfx_bad = 0;
    checkOutput({tag, "_len"}, 32'(obs_wr.size() - base), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size(); i++) begin
      if (base + i < obs_wr.size())
        checkOutput($sformatf("%s_wr%0d", tag, i), obs_wr[base+i], exp_wr[i]);
    end
    for (int i = base; i < obs_wr.size(); i++) begin
      if (obs_wr[i][17:16] == 2'd1 && obs_wr[i][15:14] != 2'b01) pfx_bad++;
    end
    checkOutput({tag, "_prefix"}, 32'(pfx_bad), 32'd0);
  endtask

  task automatic doRun(input string tag, input int s, input int n, input int lat, input int mode);
    int base, rbase, budget;
    slave_lat  = lat;
    slave_mode = mode;
    buildExpected(s, n);
    base   = obs_wr.size();
    rbase  = rd_count;
    budget = (mode == 2) ? n * (TMO + 6) + 50 : n * (8 + 2 * lat) + 50;
    applyStimulus(n, s);
    waitDone(tag, budget);
    repeat (3) @(negedge clk);
    compareTrace(tag, base);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_selbad"}, 32'(sel_bad), 32'd0);
    checkOutput({tag, "_rdbad"}, 32'(rd_bad), 32'd0);
    if (mode == 2) begin
      checkOutput({tag, "_tmo"}, 32'(tmo_cnt), 32'(n));
      checkOutput({tag, "_pass"}, 32'(pass_cnt), 32'd0);
      checkOutput({tag, "_reads"}, 32'(rd_count - rbase), 32'd0);
      for (int i = base + 1; i < wr_cyc.size(); i++)
        checkOutput($sformatf("%s_wrgap%0d", tag, i - base), 32'(wr_cyc[i] - wr_cyc[i-1]), 32'(TMO + 3));
    end else begin
      checkOutput({tag, "_pass"}, 32'(pass_cnt), 32'(mode == 1 ? n - exp_ch2 : n));
      checkOutput({tag, "_fail"}, 32'(fail_cnt), 32'(mode == 1 ? exp_ch2 : 0));
      checkOutput({tag, "_tmo"}, 32'(tmo_cnt), 32'd0);
      checkOutput({tag, "_reads"}, 32'(rd_count - rbase), 32'(n));
    end
  endtask

  initial begin
    int b0, b1, rb, sc, k, s, n;
    reset    = 1'b1;
    go       = 1'b0;
    num_iter = '0;
    seed     = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy_done", {30'd0, busy, done}, 32'd0);
    checkOutput("rst_counters", 32'(pass_cnt | fail_cnt | tmo_cnt), 32'd0);
    checkOutput("rst_start", 32'(bus.p_start), 32'd0);
    checkOutput("rst_bus", 32'({bus.p_write, bus.p_sel, bus.p_addr, bus.p_wdata}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] ideal slave, seed 1234, 50 iterations");
    doRun("ideal", 'h1234, 50, 2, 0);

    $display("[TB] corrupting slave on sel=2, 100 iterations");
    doRun("xor", 'h1234, 100, 1, 1);

    $display("[TB] silent slave, timeouts");
    doRun("tmo", 'h0BEE, 3, 2, 2);

    $display("[TB] seed 0 equals seed ACE1");
    b0 = obs_wr.size();
    doRun("seed0", 0, 20, 2, 0);
    b1 = obs_wr.size();
    doRun("seedace1", 'hACE1, 20, 2, 0);
    for (int i = 0; i < 20; i++)
      checkOutput($sformatf("seedeq%0d", i), obs_wr[b1+i], obs_wr[b0+i]);

    $display("[TB] randomized runs");
    for (int r = 0; r < 3; r++) begin
      s = $urandom_range(1, 65535);
      n = $urandom_range(4, 25);
      doRun($sformatf("rnd%0d", r), s, n, $urandom_range(1, 4), $urandom_range(0, 1));
    end

    $display("[TB] go while busy is ignored");
    slave_lat  = 2;
    slave_mode = 0;
    buildExpected('h2468, 15);
    b0 = obs_wr.size();
    applyStimulus(15, 'h2468);
    repeat (10) @(negedge clk);
    checkOutput("gobusy_busy", 32'(busy), 32'd1);
    applyStimulus(3, 'h5555);
    repeat (30) @(negedge clk);
    applyStimulus(1, 'h0);
    waitDone("gobusy", 400);
    compareTrace("gobusy", b0);
    checkOutput("gobusy_pass", 32'(pass_cnt), 32'd15);

    $display("[TB] reset during RD_WAIT");
    rb = rd_count;
    applyStimulus(10, 'h4321);
    k = 0;
    while (rd_count == rb && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("rstmid_read_seen", 32'(rd_count > rb), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sc = start_count;
    @(negedge clk);
    checkOutput("rstmid_busy_done", {30'd0, busy, done}, 32'd0);
    checkOutput("rstmid_counters", 32'(pass_cnt | fail_cnt | tmo_cnt), 32'd0);
    checkOutput("rstmid_bus", 32'({bus.p_start, bus.p_write, bus.p_sel, bus.p_addr, bus.p_wdata}), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("rstmid_nostart", 32'(start_count - sc), 32'd0);
    applyStimulus(0, 'h1111);
    checkOutput("zero_done", {30'd0, busy, done}, 32'd1);
    checkOutput("zero_counters", 32'(pass_cnt | fail_cnt | tmo_cnt), 32'd0);
    checkOutput("zero_nostart", 32'(start_count - sc), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
